// File: rtl/input_channel_fifo.sv
// Per-port input buffer: a packet-framing filter in front of a circular FIFO.
// It presents the head flit and its top nibble to the port allocator.
//
// state | meaning
// IDLE  | between packets; only a header may start a packet
// PKT   | inside a packet; payloads and back-to-back headers are stored
module input_channel_fifo #(
  parameter int FLIT_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [FLIT_W-1:0]        in_flit,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     pop,
  output logic [FLIT_W-1:0]        out_flit,
  output logic [3:0]               out_msn,
  output logic                     out_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, PKT} state_t;

  state_t            state, state_nxt;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [FLIT_W-1:0] mem [DEPTH];
  logic [1:0]        ftype;
  logic              accept, store, drop, do_pop;

  assign ftype     = in_flit[FLIT_W-1 -: 2];
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign accept    = in_valid & in_ready;
  assign do_pop    = pop & out_valid;

  always_comb begin
    store     = 1'b0;
    drop      = 1'b0;
    state_nxt = state;
    if (accept) begin
      unique case (ftype)
        2'b11: begin
          store     = 1'b1;
          state_nxt = PKT;
        end
        2'b10: begin
          if (state == PKT) store = 1'b1;
          else              drop  = 1'b1;
        end
        2'b00: state_nxt = IDLE;
        2'b01: begin
          drop      = 1'b1;
          state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (store)  wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      if (store && !do_pop)      count <= count + CW'(1);
      else if (!store && do_pop) count <= count - CW'(1);
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // Storage is not reset; the empty-forcing on the outputs hides stale entries.
  always_ff @(posedge clk) begin
    if (!rst && store) mem[wr_ptr] <= in_flit;
  end

  assign out_flit = out_valid ? mem[rd_ptr] : '0;
  assign out_msn  = out_flit[FLIT_W-1 -: 4];

endmodule

// File: tb/tb_input_channel_fifo.sv
// Directed bench for input_channel_fifo with hand-computed expectations.
module tb_input_channel_fifo;

  logic        clk;
  logic        rst;
  logic [15:0] in_flit;
  logic        in_valid;
  logic        in_ready;
  logic        pop;
  logic [15:0] out_flit;
  logic [3:0]  out_msn;
  logic        out_valid;
  logic [2:0]  count;
  logic [7:0]  drop_cnt;

  int passed = 0;
  int total  = 0;

  input_channel_fifo #(.FLIT_W(16), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid),
    .in_ready(in_ready), .pop(pop), .out_flit(out_flit), .out_msn(out_msn),
    .out_valid(out_valid), .count(count), .drop_cnt(drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; pop = 1'b0; in_flit = 16'h0000;
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_count",    32'(count),     32'h0);
    chk("rst_valid",    32'(out_valid), 32'h0);
    chk("rst_flit",     32'(out_flit),  32'h0);
    chk("rst_msn",      32'(out_msn),   32'h0);
    chk("rst_ready",    32'(in_ready),  32'h1);
    chk("rst_drop",     32'(drop_cnt),  32'h0);

    // pop while empty is ignored
    pop = 1'b1; step(); pop = 1'b0;
    chk("empty_pop_count", 32'(count), 32'h0);

    // header + 2 payloads, no bypass
    in_valid = 1'b1; in_flit = 16'hD123;
    chk("no_bypass", 32'(out_valid), 32'h0);
    step();
    chk("hdr_msn",   32'(out_msn), 32'hD);
    chk("hdr_count", 32'(count),   32'h1);
    in_flit = 16'hA001; step();
    in_flit = 16'hA002; step();
    in_valid = 1'b0;
    chk("pkt_count", 32'(count),    32'h3);
    chk("pkt_msn",   32'(out_msn),  32'hD);
    chk("pkt_head",  32'(out_flit), 32'hD123);
    pop = 1'b1;
    step(); chk("pop1", 32'(out_flit), 32'hA001);
    step(); chk("pop2", 32'(out_flit), 32'hA002);
    step(); chk("pop3", 32'(out_flit), 32'h0);
    chk("pop3_valid", 32'(out_valid), 32'h0);
    pop = 1'b0;

    // null ends packet, then orphan/illegal/null in IDLE
    in_valid = 1'b1; in_flit = 16'h0000; step();
    chk("eop_drop", 32'(drop_cnt), 32'h0);
    in_flit = 16'hA0FF; step();
    in_flit = 16'h5000; step();
    in_flit = 16'h0000; step();
    in_valid = 1'b0;
    chk("idle_drop",  32'(drop_cnt), 32'h2);
    chk("idle_count", 32'(count),    32'h0);

    // fill to full with a held fifth flit
    in_valid = 1'b1;
    in_flit = 16'hC100; step();
    in_flit = 16'hA101; step();
    in_flit = 16'hA102; step();
    in_flit = 16'hA103; step();
    chk("full_count", 32'(count),    32'h4);
    chk("full_ready", 32'(in_ready), 32'h0);
    in_flit = 16'hA104; step();
    chk("held_count", 32'(count),    32'h4);
    chk("held_head",  32'(out_flit), 32'hC100);
    pop = 1'b1; step(); pop = 1'b0;
    chk("afterpop_ready", 32'(in_ready), 32'h1);
    chk("afterpop_count", 32'(count),    32'h3);
    step();
    in_valid = 1'b0;
    chk("held_accepted", 32'(count), 32'h4);
    pop = 1'b1;
    chk("drain0", 32'(out_flit), 32'hA101);
    step(); chk("drain1", 32'(out_flit), 32'hA102);
    step(); chk("drain2", 32'(out_flit), 32'hA103);
    step(); chk("drain3", 32'(out_flit), 32'hA104);
    step(); chk("drain4", 32'(out_flit), 32'h0);
    pop = 1'b0;

    // simultaneous push/pop at count=2
    in_valid = 1'b1;
    in_flit = 16'hE200; step();
    in_flit = 16'hA201; step();
    chk("pp_start", 32'(count), 32'h2);
    pop = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_flit = 16'hA202 + 16'(k);
      step();
      chk("pp_count", 32'(count),    32'h2);
      chk("pp_head",  32'(out_flit), 32'hA201 + 32'(k));
    end
    in_valid = 1'b0;
    step(); chk("pp_tail",  32'(out_flit), 32'hA209);
    step(); chk("pp_empty", 32'(out_valid), 32'h0);
    pop = 1'b0;

    // mid-packet reset, with a handshake in the reset cycle
    in_valid = 1'b1;
    in_flit = 16'hD300; step();
    in_flit = 16'hA301; step();
    in_flit = 16'hA302; step();
    chk("mid_count", 32'(count), 32'h3);
    rst = 1'b1; in_flit = 16'hA303; step();
    rst = 1'b0; in_valid = 1'b0;
    chk("mrst_count", 32'(count),    32'h0);
    chk("mrst_msn",   32'(out_msn),  32'h0);
    chk("mrst_drop",  32'(drop_cnt), 32'h0);
    in_valid = 1'b1; in_flit = 16'hA000; step(); in_valid = 1'b0;
    chk("mrst_orphan_count", 32'(count),    32'h0);
    chk("mrst_orphan_drop",  32'(drop_cnt), 32'h1);

    // saturation
    in_valid = 1'b1; in_flit = 16'hA0FF;
    for (int k = 0; k < 253; k++) step();
    chk("sat_254", 32'(drop_cnt), 32'hFE);
    step();
    chk("sat_255", 32'(drop_cnt), 32'hFF);
    for (int k = 0; k < 6; k++) step();
    in_valid = 1'b0;
    chk("sat_hold",  32'(drop_cnt), 32'hFF);
    chk("sat_count", 32'(count),    32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/input_channel_fifo.md
# input_channel_fifo

Per-port input buffer for the symmetric butterfly switch. Accepts flits from an upstream link with a valid/ready handshake and enforces packet framing by dropping malformed flits. Stores accepted flits in a circular FIFO and presents the head flit's most-significant nibble to the port allocator. Pops the head when that port's crossbar select is asserted. One instance sits in front of each allocator input channel.

## Interface
- FLIT_W, 16: flit width in bits; must be ≥ 8.
- DEPTH, 4: FIFO entries; power of two, ≥ 2.
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_flit  input  FLIT_W  incoming flit.
  - Bits [FLIT_W-1:FLIT_W-2] are the type: 11 header, 10 payload, 00 null, 01 illegal.
  - Bits [FLIT_W-3:FLIT_W-4] are the destination port address.
- in_valid  input  1  in_flit is valid this cycle.
- in_ready  output  1  the block accepts a flit this cycle.
- pop  input  1  remove the head flit; driven by the allocator select for this port.
- out_flit  output  FLIT_W  head flit; all zeros when empty.
- out_msn  output  4  out_flit[FLIT_W-1:FLIT_W-4]; 4'b0000 (null) when empty.
- out_valid  output  1  FIFO is non-empty.
- count  output  $clog2(DEPTH)+1  number of stored flits.
- drop_cnt  output  8  number of flits dropped for framing errors; saturates at 255.

## Operation
- Handshake: a flit is accepted when in_valid & in_ready. in_ready = (count != DEPTH). It depends only on registered state, never on in_valid or pop.
- Every accepted flit goes through the framing FSM. Depending on type and state, it is stored, discarded, or dropped. Discarded and dropped flits still complete the handshake.
- FSM states: IDLE (between packets) and PKT (inside a packet). Reset state is IDLE.
  - IDLE, type 11: store; go to PKT.
  - IDLE, type 10 (orphan payload): drop; drop_cnt+1; stay in IDLE.
  - IDLE, type 00: discard silently; stay in IDLE.
  - IDLE, type 01: drop; drop_cnt+1; stay in IDLE.
  - PKT, type 10: store; stay in PKT.
  - PKT, type 11: store; stay in PKT (back-to-back packet).
  - PKT, type 00: discard silently; go to IDLE (end of packet).
  - PKT, type 01: drop; drop_cnt+1; go to IDLE.
- The FSM advances only on accepted flits. Cycles with in_valid=0 do not change state.
- Storage: write pointer wr_ptr and read pointer rd_ptr, each $clog2(DEPTH) bits, wrap modulo DEPTH.
  - A store writes mem[wr_ptr] and increments wr_ptr.
  - A pop with out_valid=1 increments rd_ptr.
- A pop while empty is ignored: no pointer or count change, no error.
- Store and pop in the same cycle: count is unchanged and both pointers advance.
- count rises by 1 on store-only and falls by 1 on pop-only. It never exceeds DEPTH and never goes below 0.
- drop_cnt holds at 255 once saturated.
- out_flit/out_msn come from mem[rd_ptr] when count > 0, and are forced to zero otherwise. Stale memory must never reach the allocator.

## Timing
- Reset: count=0, wr_ptr=rd_ptr=0, FSM=IDLE, drop_cnt=0.
  - Resulting outputs: out_valid=0, out_flit=0, out_msn=4'b0000, in_ready=1.
  - Memory contents are not reset.
- An rst assertion mid-packet discards all stored flits and returns the FSM to IDLE on that edge. Any handshake in the same cycle is ignored.
- Latency: a flit stored at edge N appears at out_flit after edge N, i.e. in cycle N+1. There is no input-to-output bypass, even when empty.
- A pop at edge N exposes the next flit (or zeros) in cycle N+1.
- Full: in_ready=0 while count=DEPTH. A pop in that cycle frees a slot, and in_ready returns to 1 in the following cycle.
- Throughput: one flit per cycle sustained when the FIFO is neither full nor empty and pop is asserted every cycle.

## Test plan
- Reset, then push header 0xD123 (type 11, dest 01) and payloads 0xA001, 0xA002 on consecutive cycles, with pop=0.
  - Required: out_msn=4'hD from the cycle after the first push, and count=3.
  - Then pop for three cycles: out_flit sequence 0xD123, 0xA001, 0xA002, then 0x0000 with out_valid=0.
- Orphan and illegal flits in IDLE: push 0xA0FF, 0x5000, 0x0000.
  - Required: nothing stored, drop_cnt=2, count=0.
- Fill to DEPTH=4 (header plus 3 payloads) with in_valid held high on a 5th flit.
  - Required: in_ready=0 and the 5th flit not accepted.
  - Pop once: in_ready=1 the next cycle, and the held flit is accepted.
- Simultaneous push and pop at count=2 for 8 cycles.
  - Required: count stays 2, pointers wrap past DEPTH-1, and flit order is preserved.
- Mid-packet reset: push header plus 2 payloads, assert rst for one cycle.
  - Required: count=0, out_msn=0, drop_cnt=0.
  - A following payload 0xA000 is dropped, since the FSM is in IDLE.
- Saturation: push 260 orphan payloads.
  - Required: drop_cnt=255 and holds there.
